// File: rtl/pu_iteration_controller_if.sv
// Handshake and control bundle between the Maxnet sequencer,
// the start/done host side and the PU bank with its input muxes.
interface pu_iteration_controller_if #(
   parameter int NUM_PU = 4,
   parameter int ITER_W = 8
);
   logic              start;
   logic [NUM_PU-1:0] s;
   logic              sel_init;
   logic              load_x;
   logic              load_mult;
   logic              load_sum;
   logic              busy;
   logic              done;
   logic [NUM_PU-1:0] winner;
   logic              no_winner;
   logic              timeout;
   logic [ITER_W-1:0] iter_count;

   modport master (
      output start,
      output s,
      input  sel_init,
      input  load_x,
      input  load_mult,
      input  load_sum,
      input  busy,
      input  done,
      input  winner,
      input  no_winner,
      input  timeout,
      input  iter_count
   );

   modport slave (
      input  start,
      input  s,
      output sel_init,
      output load_x,
      output load_mult,
      output load_sum,
      output busy,
      output done,
      output winner,
      output no_winner,
      output timeout,
      output iter_count
   );
endinterface

// File: rtl/pu_iteration_controller.sv
// Maxnet winner-take-all sequencer: load, multiply, sum, check
// per iteration until one survivor, none, or the iteration cap.
module pu_iteration_controller #(
   parameter int NUM_PU   = 4,
   parameter int MAX_ITER = 16,
   parameter int ITER_W   = 8
) (
   input  logic clock,
   input  logic reset_n,
   pu_iteration_controller_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MULT,
      SUM,
      CHECK,
      DONE
   } state_t;

   localparam logic [NUM_PU-1:0] ONE = NUM_PU'(1);
   localparam logic [ITER_W-1:0] CAP = ITER_W'(MAX_ITER);

   state_t            state;
   logic              sel_init_q;
   logic              load_x_q;
   logic              load_mult_q;
   logic              load_sum_q;
   logic              busy_q;
   logic              done_q;
   logic [NUM_PU-1:0] winner_q;
   logic              no_winner_q;
   logic              timeout_q;
   logic [ITER_W-1:0] iter_q;

   logic              s_zero;
   logic              s_single;
   logic [ITER_W-1:0] iter_inc;

   // Clearing the lowest set bit leaves zero only for one-hot s.
   always_comb begin
      s_zero   = (bus.s == '0);
      s_single = !s_zero && ((bus.s & (bus.s - ONE)) == '0);
      iter_inc = iter_q + ITER_W'(1);
   end

   // Strobes are registered one edge early, so each one is
   // high exactly during the state it belongs to.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         sel_init_q  <= 1'b0;
         load_x_q    <= 1'b0;
         load_mult_q <= 1'b0;
         load_sum_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         winner_q    <= '0;
         no_winner_q <= 1'b0;
         timeout_q   <= 1'b0;
         iter_q      <= '0;
      end else begin
         sel_init_q  <= 1'b0;
         load_x_q    <= 1'b0;
         load_mult_q <= 1'b0;
         load_sum_q  <= 1'b0;
         done_q      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state       <= LOAD;
                  busy_q      <= 1'b1;
                  load_x_q    <= 1'b1;
                  sel_init_q  <= 1'b1;
                  winner_q    <= '0;
                  no_winner_q <= 1'b0;
                  timeout_q   <= 1'b0;
                  iter_q      <= '0;
               end
            end
            LOAD: begin
               state       <= MULT;
               load_mult_q <= 1'b1;
            end
            MULT: begin
               state      <= SUM;
               load_sum_q <= 1'b1;
            end
            SUM: begin
               state <= CHECK;
            end
            CHECK: begin
               iter_q <= iter_inc;
               if (s_single) begin
                  winner_q <= bus.s;
                  state    <= DONE;
                  done_q   <= 1'b1;
               end else if (s_zero) begin
                  no_winner_q <= 1'b1;
                  state       <= DONE;
                  done_q      <= 1'b1;
               end else if (iter_inc == CAP) begin
                  timeout_q <= 1'b1;
                  state     <= DONE;
                  done_q    <= 1'b1;
               end else begin
                  state    <= LOAD;
                  load_x_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel_init   = sel_init_q;
   assign bus.load_x     = load_x_q;
   assign bus.load_mult  = load_mult_q;
   assign bus.load_sum   = load_sum_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.winner     = winner_q;
   assign bus.no_winner  = no_winner_q;
   assign bus.timeout    = timeout_q;
   assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_pu_iteration_controller.sv
// Randomized bench for the Maxnet sequencer against a
// per-run schedule model derived from the iteration rules.
module tb_pu_iteration_controller;

   localparam int NUM_PU   = 4;
   localparam int MAX_ITER = 4;
   localparam int ITER_W   = 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   pu_iteration_controller_if #(
      .NUM_PU(NUM_PU),
      .ITER_W(ITER_W)
   ) bus ();

   pu_iteration_controller #(
      .NUM_PU(NUM_PU),
      .MAX_ITER(MAX_ITER),
      .ITER_W(ITER_W)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic [3:0] sq [MAX_ITER];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int pc(input logic [3:0] v);
      int c = 0;
      for (int i = 0; i < 4; i++) c += int'(v[i]);
      return c;
   endfunction

   // Outcome of a run from the list of s values seen at each check.
   task automatic model(output int n, output logic [3:0] w,
                        output bit nw, output bit to);
      bit fin = 0;
      n = 0; w = '0; nw = 0; to = 0;
      for (int i = 0; i < MAX_ITER && !fin; i++) begin
         n = i + 1;
         if (pc(sq[i]) == 1) begin
            w = sq[i]; fin = 1;
         end else if (pc(sq[i]) == 0) begin
            nw = 1; fin = 1;
         end else if (n == MAX_ITER) begin
            to = 1; fin = 1;
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".busy"}, bus.busy, 0);
      chk({tag, ".done"}, bus.done, 0);
      chk({tag, ".ld"}, {bus.load_x, bus.load_mult,
                         bus.load_sum, bus.sel_init}, 0);
      chk({tag, ".win"}, bus.winner, 0);
      chk({tag, ".flags"}, {bus.no_winner, bus.timeout}, 0);
      chk({tag, ".iter"}, bus.iter_count, 0);
   endtask

   // LOAD begins at the edge that samples start; iteration i
   // occupies offsets 4i..4i+3 and done lands at offset 4n.
   task automatic run(input bit retrig, input bit hold);
      int n;
      int ph;
      logic [3:0] w;
      bit nw, to;
      model(n, w, nw, to);
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      for (int t = 0; t <= 4 * n; t++) begin
         ph = t % 4;
         if (t == 0) bus.start = 1'b0;
         if (retrig && t == 1) bus.start = 1'b1;
         if (retrig && t == 2) bus.start = 1'b0;
         if (hold && t == 4 * n) bus.start = 1'b1;
         if (ph == 3 && t < 4 * n) bus.s = sq[t / 4];
         else bus.s = 4'($urandom);
         if (t < 4 * n) begin
            chk("busy", bus.busy, 1);
            chk("load_x", bus.load_x, 32'(ph == 0));
            chk("load_mult", bus.load_mult, 32'(ph == 1));
            chk("load_sum", bus.load_sum, 32'(ph == 2));
            chk("sel_init", bus.sel_init, 32'(t == 0));
            chk("done_early", bus.done, 0);
            chk("iter_run", bus.iter_count, 32'(t / 4));
            chk("win_run", bus.winner, 0);
            chk("flags_run", {bus.no_winner, bus.timeout}, 0);
         end else begin
            chk("done", bus.done, 1);
            chk("busy_done", bus.busy, 1);
            chk("ld_done", {bus.load_x, bus.load_mult,
                            bus.load_sum, bus.sel_init}, 0);
            chk("winner", bus.winner, 32'(w));
            chk("no_winner", bus.no_winner, 32'(nw));
            chk("timeout", bus.timeout, 32'(to));
            chk("iter_count", bus.iter_count, 32'(n));
         end
         @(negedge clock);
      end
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_ld", {bus.load_x, bus.load_mult,
                      bus.load_sum, bus.sel_init}, 0);
      chk("hold_win", bus.winner, 32'(w));
      chk("hold_flags", {bus.no_winner, bus.timeout}, {nw, to});
      chk("hold_iter", bus.iter_count, 32'(n));
   endtask

   task automatic reset_mid_run();
      for (int i = 0; i < MAX_ITER; i++) sq[i] = 4'hF;
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      for (int t = 0; t < 6; t++) begin
         bus.s = (t % 4 == 3) ? 4'hF : 4'($urandom);
         @(negedge clock);
      end
      chk("rst_pre_sum", bus.load_sum, 1);
      chk("rst_pre_iter", bus.iter_count, 1);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("rst_async");
      @(negedge clock);
      reset_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
         bus.s = 4'($urandom);
         @(negedge clock);
         chk("rst_idle_busy", bus.busy, 0);
         chk("rst_idle_ldx", bus.load_x, 0);
      end
   endtask

   function automatic logic [3:0] rand_s();
      int r = $urandom_range(0, 9);
      logic [3:0] v;
      if (r == 0) return 4'h0;
      if (r < 3) return 4'(1 << $urandom_range(0, 3));
      v = 4'($urandom);
      while (pc(v) < 2) v = 4'($urandom);
      return v;
   endfunction

   initial begin
      bit hold;
      bus.start = 1'b0;
      bus.s = '0;
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      chk("idle_after_reset", bus.busy, 0);

      sq = '{4'b0100, 4'b1111, 4'b1111, 4'b1111};
      run(0, 0);
      sq = '{4'b1111, 4'b0110, 4'b0010, 4'b1111};
      run(0, 0);
      sq = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
      run(0, 0);
      sq = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
      run(0, 0);
      sq = '{4'b1111, 4'b0001, 4'b1111, 4'b1111};
      run(1, 1);
      sq = '{4'b1010, 4'b1000, 4'b1111, 4'b1111};
      run(0, 0);
      repeat (2) @(negedge clock);
      reset_mid_run();

      hold = 0;
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < MAX_ITER; i++) sq[i] = rand_s();
         hold = (k < 29) && ($urandom_range(0, 3) == 0);
         run(1'($urandom_range(0, 1)), hold);
         if (!hold) repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
